mul_unit: RTL and testbench

//  Multi-cycle MUL/MLA execute unit fed by the register file read ports (p0 -> op_a, p1 -> op_b).

---
 rtl/mul_unit.sv | 120 ++++++++++++
 tb/tb_mul_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Multi-cycle MUL/MLA execute unit: iterative radix-2^STEP shift-add multiplier with
// optional accumulate, presenting result, writeback select and NZCV flags for one cycle.
module mul_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             start,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_acc,
    input  logic [3:0]       dest,
    input  logic [3:0]       in_flags,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       wr_sel,
    output logic [3:0]       out_flags,
    output logic             flags_we
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [3:0]         dest_l;
    logic               set_flags_l;
    logic [1:0]         cv_l;
    logic               last_step;
    logic               unused_nz;

    // N and Z are recomputed from the product; only C and V pass through.
    assign unused_nz = ^in_flags[3:2];

    assign last_step = (count == CNT_W'(N - 1));

    // mcand is pre-shifted each step, so the partial product needs no variable shift.
    assign acc_nxt = acc + mcand * WIDTH'(mplier[STEP-1:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (!hold) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_step) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            dest_l      <= 4'hF;
            set_flags_l <= 1'b0;
            cv_l        <= 2'b00;
            result      <= '0;
            out_flags   <= 4'b0000;
        end else if (!hold) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand       <= op_a;
                        mplier      <= op_b;
                        dest_l      <= dest;
                        set_flags_l <= set_flags;
                        cv_l        <= in_flags[1:0];
                        acc         <= accumulate ? op_acc : '0;
                        count       <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << STEP;
                    mplier <= mplier >> STEP;
                    count  <= count + CNT_W'(1);
                    if (last_step) begin
                        result    <= acc_nxt;
                        out_flags <= {acc_nxt[WIDTH-1], acc_nxt == '0, cv_l};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign wr_sel   = done ? dest_l : 4'hF;
    assign flags_we = done & set_flags_l;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: table of directed MUL/MLA vectors plus
// hand-written hold, ignored-start, back-to-back and abort-by-reset sequences.
module tb_mul_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic        start;
    logic        accumulate;
    logic        set_flags;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_acc;
    logic [3:0]  dest;
    logic [3:0]  in_flags;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  wr_sel;
    logic [3:0]  out_flags;
    logic        flags_we;

    int total = 0;
    int bad   = 0;

    mul_unit #(.WIDTH(32), .STEP(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .start     (start),
        .accumulate(accumulate),
        .set_flags (set_flags),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_acc    (op_acc),
        .dest      (dest),
        .in_flags  (in_flags),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .wr_sel    (wr_sel),
        .out_flags (out_flags),
        .flags_we  (flags_we)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic        mla;
        logic        s;
        logic [3:0]  dest;
        logic [3:0]  flags;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_sel;
        logic        exp_we;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (!done && edges < budget) begin
            tick();
            edges++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: no done within %0d edges", budget);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic mla, input logic s, input logic [3:0] d,
                        input logic [3:0] f);
        op_a       = a;
        op_b       = b;
        op_acc     = c;
        accumulate = mla;
        set_flags  = s;
        dest       = d;
        in_flags   = f;
    endtask

    // Garble every operand input after acceptance to prove they were latched.
    task automatic scramble();
        op_a       = ~op_a;
        op_b       = ~op_b;
        op_acc     = ~op_acc;
        accumulate = ~accumulate;
        set_flags  = ~set_flags;
        dest       = ~dest;
        in_flags   = ~in_flags;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        int pulses;

        vecs[0] = '{32'h12345678, 32'h10,       32'h0, 1'b0, 1'b1, 4'd5,  4'b0000, 32'h23456780, 4'b0000, 4'd5,  1'b1};
        vecs[1] = '{32'h3,        32'h5,        32'h7, 1'b1, 1'b0, 4'd6,  4'b0000, 32'h16,       4'b0000, 4'd6,  1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 4'd1,  4'b0000, 32'h1,        4'b0000, 4'd1,  1'b1};
        vecs[3] = '{32'h80000000, 32'h1,        32'h0, 1'b0, 1'b1, 4'd2,  4'b0000, 32'h80000000, 4'b1000, 4'd2,  1'b1};
        vecs[4] = '{32'h0,        32'h1234,     32'h0, 1'b0, 1'b1, 4'd3,  4'b0011, 32'h0,        4'b0111, 4'd3,  1'b1};
        vecs[5] = '{32'h2,        32'h3,        32'h0, 1'b0, 1'b1, 4'hF,  4'b1101, 32'h6,        4'b0001, 4'hF,  1'b1};
        vecs[6] = '{32'h10000,    32'h10000,    32'h5, 1'b1, 1'b1, 4'd7,  4'b0000, 32'h5,        4'b0000, 4'd7,  1'b1};
        vecs[7] = '{32'hDEADBEEF, 32'h3,        32'h0, 1'b0, 1'b1, 4'd8,  4'b0010, 32'h9C093CCD, 4'b1010, 4'd8,  1'b1};
        vecs[8] = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 1'b0, 1'b0, 4'd9,  4'b0000, 32'h6,        4'b0000, 4'd9,  1'b0};

        reset = 1'b1;
        hold  = 1'b0;
        start = 1'b0;
        load(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (3) tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 32'h0);
        check("reset wr_sel", wr_sel, 4'hF);
        check("reset out_flags", out_flags, 4'h0);
        check("reset flags_we", flags_we, 1'b0);
        reset = 1'b0;
        tick();

        hold  = 1'b1;
        start = 1'b1;
        tick();
        check("held idle ignores start", busy, 1'b0);
        hold  = 1'b0;
        start = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            load(vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].mla, vecs[i].s, vecs[i].dest, vecs[i].flags);
            start = 1'b1;
            tick();
            start = 1'b0;
            scramble();
            check($sformatf("v%0d busy", i), busy, 1'b1);
            wait_done(40, n);
            check($sformatf("v%0d latency", i), n, 16);
            check($sformatf("v%0d result", i), result, vecs[i].exp_res);
            check($sformatf("v%0d wr_sel", i), wr_sel, vecs[i].exp_sel);
            check($sformatf("v%0d out_flags", i), out_flags, vecs[i].exp_flags);
            check($sformatf("v%0d flags_we", i), flags_we, vecs[i].exp_we);
            tick();
            check($sformatf("v%0d done off", i), done, 1'b0);
            check($sformatf("v%0d wr_sel off", i), wr_sel, 4'hF);
            check($sformatf("v%0d flags_we off", i), flags_we, 1'b0);
            check($sformatf("v%0d result held", i), result, vecs[i].exp_res);
            check($sformatf("v%0d idle", i), busy, 1'b0);
        end

        // Hold for three cycles mid-run, then hold twice while done.
        load(32'h1111, 32'h3, 32'h0, 1'b0, 1'b1, 4'd4, 4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        hold = 1'b1;
        repeat (3) tick();
        check("hold busy", busy, 1'b1);
        check("hold no done", done, 1'b0);
        hold = 1'b0;
        wait_done(40, n);
        check("hold latency", n + 8, 19);
        check("hold result", result, 32'h3333);
        hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("held done %0d", k), done, 1'b1);
            check($sformatf("held wr_sel %0d", k), wr_sel, 4'd4);
        end
        hold = 1'b0;
        tick();
        check("held done released", done, 1'b0);
        check("held result kept", result, 32'h3333);

        // A start pulse during RUN must not disturb the operation in flight.
        load(32'd7, 32'd6, 32'h0, 1'b0, 1'b0, 4'd10, 4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        load(32'd9, 32'd9, 32'h0, 1'b0, 1'b0, 4'd11, 4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, n);
        check("ignored start latency", n + 5, 16);
        check("ignored start result", result, 32'd42);
        check("ignored start wr_sel", wr_sel, 4'd10);
        tick();
        tick();
        check("ignored start not queued", busy, 1'b0);

        // start held high: a new operation is accepted every N+2 cycles.
        load(32'd2, 32'd3, 32'h0, 1'b0, 1'b0, 4'd12, 4'b0000);
        start = 1'b1;
        tick();
        load(32'd4, 32'd5, 32'h0, 1'b0, 1'b0, 4'd13, 4'b0000);
        wait_done(40, n);
        check("b2b first latency", n, 16);
        check("b2b first result", result, 32'd6);
        tick();
        n2 = 1;
        wait_done(40, n);
        start = 1'b0;
        check("b2b spacing", n2 + n, 18);
        check("b2b second result", result, 32'd20);
        check("b2b second wr_sel", wr_sel, 4'd13);
        repeat (2) tick();

        // Reset at count 7 aborts without ever pulsing done.
        load(32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 4'd14, 4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort wr_sel", wr_sel, 4'hF);
        check("abort result", result, 32'h0);
        check("abort flags_we", flags_we, 1'b0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done) pulses++;
        end
        check("abort no done pulse", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
